// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable data bits, oversampling and stop bits.
// Define UART_TX_PARITY_EN to insert one parity bit between the data and stop bits.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 parity_odd,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy,
  output logic                 tx_done_tick,
  output logic                 tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(STOP_BITS * OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count, count_n;
  logic                 push, pop;

  // A full FIFO rejects the write even when a pop frees a slot this cycle.
  assign push = wr_en && !full;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // NOTE: the storage array has no reset; clearing the pointers and count is
  // enough to discard its contents, and leaving it reset-free keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_n;
      full     <= (count_n == DEPTH_CNT);
      empty    <= (count_n == '0);
      overflow <= wr_en && full;
    end
  end

  // ----------------------------------------------------------- serializer
  state_t               state, state_n;
  logic [TW-1:0]        tick, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_n;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign busy = (state != IDLE);

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    tick_n       = tick;
    bit_n        = bit_cnt;
    shreg_n      = shreg;
    tx_n         = tx;
    pop          = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n        = par;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
          par_n   = (^mem[rd_ptr]) ^ parity_odd;
`endif
          tick_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick == BIT_LAST) begin
            tick_n  = '0;
            tx_n    = shreg[0];
            state_n = DATA;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick == BIT_LAST) begin
            tick_n  = '0;
            shreg_n = shreg >> 1;
            if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_n    = par;
              state_n = PARITY;
`else
              tx_n    = 1'b1;
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_cnt + 1'b1;
              tx_n  = shreg[1];
            end
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick == BIT_LAST) begin
            tick_n  = '0;
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick == STOP_LAST) begin
            tick_n       = '0;
            tx_done_tick = 1'b1;
            state_n      = IDLE;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values no matter how the simulator orders the processes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule
